// File: rtl/ula_operand_stage.sv
// ID/EX operand stage feeding the 32-bit ALU: operand select, RAW forwarding, load-use bubbles.
// Build option ULA_FWD_EN: defined adds EX/MEM and MEM/WB forwarding; undefined stalls on every RAW hazard.
module ula_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [3:0]        dec_op,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [DATA_W-1:0] dec_rs_val,
  input  logic [DATA_W-1:0] dec_rt_val,
  input  logic [IMM_W-1:0]  dec_imm,
  input  logic              dec_use_imm,
  input  logic              dec_is_load,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_wr_en,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  output logic [3:0]        ula_op,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_is_load,
  output logic [15:0]       stall_cnt
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              is_load_q, is_load_d;
  logic [15:0]       stall_q, stall_d;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] src_a, src_b;
  logic [DATA_W-1:0] held_a, held_b;
  logic              hz, accept, bubble;

  // Logical ops (AND/OR/XOR) take a zero-extended immediate; arithmetic ops sign-extend.
  always_comb begin
    if (dec_op == 4'b0000 || dec_op == 4'b0001 || dec_op == 4'b0011)
      imm_ext = {{(DATA_W-IMM_W){1'b0}}, dec_imm};
    else
      imm_ext = {{(DATA_W-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};
  end

`ifdef ULA_FWD_EN
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d;
  logic              use_imm_q, use_imm_d;

  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [REG_AW-1:0] r,
    input logic [DATA_W-1:0] dflt,
    input logic              e_we,
    input logic [REG_AW-1:0] e_rd,
    input logic [DATA_W-1:0] e_res,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic [DATA_W-1:0] m_res
  );
    if (r == '0)                  return dflt;
    else if (e_we && e_rd == r)   return e_res;
    else if (m_we && m_rd == r)   return m_res;
    else                          return dflt;
  endfunction

  assign src_a  = fwd_pick(dec_rs, dec_rs_val, exm_wr_en, exm_rd, exm_result,
                           mwb_wr_en, mwb_rd, mwb_result);
  assign src_b  = dec_use_imm ? imm_ext
                : fwd_pick(dec_rt, dec_rt_val, exm_wr_en, exm_rd, exm_result,
                           mwb_wr_en, mwb_rd, mwb_result);
  // A held instruction keeps snooping writebacks so its operands never go stale.
  assign held_a = fwd_pick(rs_q, a_q, exm_wr_en, exm_rd, exm_result,
                           mwb_wr_en, mwb_rd, mwb_result);
  assign held_b = use_imm_q ? b_q
                : fwd_pick(rt_q, b_q, exm_wr_en, exm_rd, exm_result,
                           mwb_wr_en, mwb_rd, mwb_result);

  assign hz = ex_valid_q & is_load_q & (rd_q != '0) &
              ((dec_rs == rd_q) | (!dec_use_imm & (dec_rt == rd_q)));

  assign rs_d      = accept ? dec_rs      : rs_q;
  assign rt_d      = accept ? dec_rt      : rt_q;
  assign use_imm_d = accept ? dec_use_imm : use_imm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_q      <= '0;
      rt_q      <= '0;
      use_imm_q <= 1'b0;
    end else begin
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      use_imm_q <= use_imm_d;
    end
  end
`else
  function automatic logic raw_hit(
    input logic [REG_AW-1:0] r,
    input logic              e_we,
    input logic [REG_AW-1:0] e_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              x_v,
    input logic [REG_AW-1:0] x_rd
  );
    return (r != '0) && ((e_we && e_rd == r) || (m_we && m_rd == r) || (x_v && x_rd == r));
  endfunction

  assign src_a  = dec_rs_val;
  assign src_b  = dec_use_imm ? imm_ext : dec_rt_val;
  assign held_a = a_q;
  assign held_b = b_q;

  assign hz = raw_hit(dec_rs, exm_wr_en, exm_rd, mwb_wr_en, mwb_rd, ex_valid_q, rd_q) |
              (!dec_use_imm &
               raw_hit(dec_rt, exm_wr_en, exm_rd, mwb_wr_en, mwb_rd, ex_valid_q, rd_q));

  // Result buses are only consumed by the forwarding build.
  logic unused_fwd;
  assign unused_fwd = ^{exm_result, mwb_result};
`endif

  assign dec_ready = (!ex_valid_q | ex_ready) & !hz & !flush;
  assign accept    = dec_valid & dec_ready;
  assign bubble    = dec_valid & hz & (!ex_valid_q | ex_ready) & !flush;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch below can infer a latch.
    ex_valid_d = ex_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rd_d       = rd_q;
    is_load_d  = is_load_q;
    stall_d    = stall_q;

    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      a_d        = src_a;
      b_d        = src_b;
      op_d       = dec_op;
      rd_d       = dec_rd;
      is_load_d  = dec_is_load;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end else if (ex_valid_q) begin
      a_d = held_a;
      b_d = held_b;
    end

    if (bubble && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      is_load_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      stall_q    <= stall_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ula_a      = a_q;
  assign ula_b      = b_q;
  assign ula_op     = op_q;
  assign ex_rd      = rd_q;
  assign ex_is_load = is_load_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_ula_operand_stage.sv
// Bench for ula_operand_stage: table vectors checked through a scoreboard, then hand-written
// sequences for forwarding, load-use, backpressure, flush and asynchronous reset.
module tb_ula_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  dec_op;
  logic [4:0]  dec_rs, dec_rt, dec_rd;
  logic [31:0] dec_rs_val, dec_rt_val;
  logic [15:0] dec_imm;
  logic        dec_use_imm, dec_is_load;
  logic        exm_wr_en, mwb_wr_en;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid, ex_ready;
  logic [31:0] ula_a, ula_b;
  logic [3:0]  ula_op;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic [15:0] stall_cnt;

  ula_operand_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
    .dec_rs_val(dec_rs_val), .dec_rt_val(dec_rt_val), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_is_load(dec_is_load),
    .exm_wr_en(exm_wr_en), .mwb_wr_en(mwb_wr_en),
    .exm_rd(exm_rd), .mwb_rd(mwb_rd),
    .exm_result(exm_result), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_val, rt_val;
    logic [15:0] imm;
    logic        use_imm, is_load;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        is_load;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  int   exp_stall = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dec(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rs_val,
                           input logic [31:0] rt_val, input logic [15:0] imm,
                           input logic use_imm, input logic is_load);
    dec_valid   = 1'b1;
    dec_op      = op;
    dec_rs      = rs;
    dec_rt      = rt;
    dec_rd      = rd;
    dec_rs_val  = rs_val;
    dec_rt_val  = rt_val;
    dec_imm     = imm;
    dec_use_imm = use_imm;
    dec_is_load = is_load;
  endtask

  task automatic idle_dec();
    drive_dec(4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0);
    dec_valid = 1'b0;
  endtask

  // Scoreboard: an entry is retired whenever EX consumes the presented instruction.
  always @(negedge clk) begin
    if (mon_en && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_pop got=empty_queue required=pending_entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ula_a", ula_a, e.a);
        check("sb_ula_b", ula_b, e.b);
        check("sb_ula_op", {28'h0, ula_op}, {28'h0, e.op});
        check("sb_ex_rd", {27'h0, ex_rd}, {27'h0, e.rd});
        check("sb_ex_is_load", {31'h0, ex_is_load}, {31'h0, e.is_load});
      end
    end
  end

  initial begin
    vec_t vecs[8];
    exp_t e;

    vecs[0] = '{4'h2, 5'd1,  5'd2,  5'd20, 32'h11, 32'h22,        16'hFFF0, 1'b1, 1'b0, 32'h11, 32'hFFFF_FFF0};
    vecs[1] = '{4'h1, 5'd3,  5'd4,  5'd21, 32'h33, 32'h44,        16'hFFF0, 1'b1, 1'b0, 32'h33, 32'h0000_FFF0};
    vecs[2] = '{4'h0, 5'd5,  5'd6,  5'd22, 32'h55, 32'h66,        16'h8001, 1'b1, 1'b0, 32'h55, 32'h0000_8001};
    vecs[3] = '{4'h3, 5'd7,  5'd8,  5'd23, 32'h77, 32'h88,        16'h8000, 1'b1, 1'b0, 32'h77, 32'h0000_8000};
    vecs[4] = '{4'h4, 5'd9,  5'd10, 5'd24, 32'h99, 32'hAA,        16'h7FFF, 1'b1, 1'b0, 32'h99, 32'h0000_7FFF};
    vecs[5] = '{4'h5, 5'd11, 5'd12, 5'd25, 32'hBB, 32'hDEAD_BEEF, 16'hFFFF, 1'b0, 1'b0, 32'hBB, 32'hDEAD_BEEF};
    vecs[6] = '{4'hF, 5'd13, 5'd14, 5'd26, 32'hCC, 32'hDD,        16'h8000, 1'b1, 1'b0, 32'hCC, 32'hFFFF_8000};
    vecs[7] = '{4'h7, 5'd0,  5'd0,  5'd27, 32'hCAFE_0001, 32'h1234_5678, 16'h0000, 1'b0, 1'b1, 32'hCAFE_0001, 32'h1234_5678};

    reset_n = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b0;
    exm_wr_en = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_wr_en = 1'b0; mwb_rd = '0; mwb_result = '0;
    idle_dec();
    #12;
    check("rst_ex_valid", {31'h0, ex_valid}, 32'h0);
    check("rst_ula_a", ula_a, 32'h0);
    check("rst_ula_b", ula_b, 32'h0);
    check("rst_ula_op", {28'h0, ula_op}, 32'h0);
    check("rst_ex_rd", {27'h0, ex_rd}, 32'h0);
    check("rst_ex_is_load", {31'h0, ex_is_load}, 32'h0);
    check("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back table: consume and capture on the same edge, no bubbles expected.
    mon_en = 1'b1;
    ex_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive_dec(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rs_val,
                vecs[i].rt_val, vecs[i].imm, vecs[i].use_imm, vecs[i].is_load);
      #1;
      check("tbl_dec_ready", {31'h0, dec_ready}, 32'h1);
      e.a = vecs[i].exp_a;
      e.b = vecs[i].exp_b;
      e.op = vecs[i].op;
      e.rd = vecs[i].rd;
      e.is_load = vecs[i].is_load;
      sb.push_back(e);
    end
    tick();
    idle_dec();
    tick();
    tick();
    check("tbl_sb_drained", sb.size(), 32'd0);
    check("tbl_ex_valid_drained", {31'h0, ex_valid}, 32'h0);
    mon_en = 1'b0;

    // Forwarding priority / register zero.
    drive_dec(4'h2, 5'd5, 5'd0, 5'd10, 32'h1111, 32'h0, 16'h0, 1'b1, 1'b0);
    exm_wr_en = 1'b1; exm_rd = 5'd5; exm_result = 32'hAAAA;
    mwb_wr_en = 1'b1; mwb_rd = 5'd5; mwb_result = 32'hBBBB;
`ifdef ULA_FWD_EN
    tick();
    check("fwd_exm_priority", ula_a, 32'hAAAA);
`else
    #1;
    check("nofwd_raw_dec_ready", {31'h0, dec_ready}, 32'h0);
    tick();
    exp_stall++;
    check("nofwd_raw_bubble", {31'h0, ex_valid}, 32'h0);
    check("nofwd_raw_stall_cnt", {16'h0, stall_cnt}, exp_stall);
    exm_wr_en = 1'b0;
    mwb_wr_en = 1'b0;
    #1;
    check("nofwd_raw_release", {31'h0, dec_ready}, 32'h1);
    tick();
    check("nofwd_regfile_a", ula_a, 32'h1111);
`endif
    drive_dec(4'h2, 5'd0, 5'd0, 5'd10, 32'h2222, 32'h0, 16'h0, 1'b1, 1'b0);
    exm_wr_en = 1'b1; exm_rd = 5'd0; exm_result = 32'hAAAA;
    mwb_wr_en = 1'b1; mwb_rd = 5'd0; mwb_result = 32'hBBBB;
    tick();
    check("fwd_r0_regfile", ula_a, 32'h2222);
`ifdef ULA_FWD_EN
    drive_dec(4'h2, 5'd5, 5'd0, 5'd10, 32'h1111, 32'h0, 16'h0, 1'b1, 1'b0);
    exm_wr_en = 1'b0;
    mwb_wr_en = 1'b1; mwb_rd = 5'd5; mwb_result = 32'hBBBB;
    tick();
    check("fwd_mwb_only", ula_a, 32'hBBBB);
`endif
    exm_wr_en = 1'b0;
    mwb_wr_en = 1'b0;

    // Load-use: one bubble, then the dependent op picks up the loaded value.
    drive_dec(4'h2, 5'd1, 5'd2, 5'd8, 32'h100, 32'h0, 16'h0004, 1'b1, 1'b1);
    tick();
    check("ld_ex_is_load", {31'h0, ex_is_load}, 32'h1);
    check("ld_ex_rd", {27'h0, ex_rd}, 32'd8);
    drive_dec(4'h5, 5'd2, 5'd8, 5'd12, 32'h2, 32'h0, 16'h0, 1'b0, 1'b0);
    #1;
    check("lu_dec_ready", {31'h0, dec_ready}, 32'h0);
    tick();
    exp_stall++;
    check("lu_bubble", {31'h0, ex_valid}, 32'h0);
    check("lu_stall_cnt", {16'h0, stall_cnt}, exp_stall);
`ifdef ULA_FWD_EN
    mwb_wr_en = 1'b1; mwb_rd = 5'd8; mwb_result = 32'h5A5A_0008;
`else
    dec_rt_val = 32'h5A5A_0008;
`endif
    #1;
    check("lu_accept_ready", {31'h0, dec_ready}, 32'h1);
    tick();
    check("lu_ex_valid", {31'h0, ex_valid}, 32'h1);
    check("lu_ula_b", ula_b, 32'h5A5A_0008);
    check("lu_ula_op", {28'h0, ula_op}, 32'h5);
    mwb_wr_en = 1'b0;

    // Backpressure with a writeback to the held rs during the hold.
    drive_dec(4'h6, 5'd3, 5'd4, 5'd13, 32'h0F0F, 32'h7, 16'h0, 1'b0, 1'b0);
    tick();
    check("bp_capture_a", ula_a, 32'h0F0F);
    ex_ready = 1'b0;
    drive_dec(4'h9, 5'd1, 5'd2, 5'd14, 32'h91, 32'h92, 16'h0, 1'b0, 1'b0);
    mwb_wr_en = 1'b1; mwb_rd = 5'd3; mwb_result = 32'h1234;
    #1;
    check("bp_dec_ready", {31'h0, dec_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_ex_valid", {31'h0, ex_valid}, 32'h1);
`ifdef ULA_FWD_EN
      check("bp_refresh_a", ula_a, 32'h1234);
`else
      check("bp_held_a", ula_a, 32'h0F0F);
`endif
      check("bp_ula_op", {28'h0, ula_op}, 32'h6);
      check("bp_hold_ready", {31'h0, dec_ready}, 32'h0);
    end
    mwb_wr_en = 1'b0;
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'h0, dec_ready}, 32'h1);
    tick();
    check("bp_next_op", {28'h0, ula_op}, 32'h9);
    check("bp_next_a", ula_a, 32'h91);

    // Flush beats capture.
    drive_dec(4'hA, 5'd1, 5'd2, 5'd15, 32'hA1, 32'hA2, 16'h0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_dec_ready", {31'h0, dec_ready}, 32'h0);
    tick();
    check("fl_ex_valid", {31'h0, ex_valid}, 32'h0);
    check("fl_ula_op_kept", {28'h0, ula_op}, 32'h9);
    check("fl_stall_cnt", {16'h0, stall_cnt}, exp_stall);
    flush = 1'b0;

    // Asynchronous reset while an instruction is presented.
    drive_dec(4'h2, 5'd1, 5'd0, 5'd16, 32'h77, 32'h0, 16'h0, 1'b1, 1'b0);
    tick();
    check("ar_pre_ex_valid", {31'h0, ex_valid}, 32'h1);
    check("ar_pre_ula_a", ula_a, 32'h77);
    check("ar_pre_stall_cnt", {16'h0, stall_cnt}, exp_stall);
    idle_dec();
    ex_ready = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_ex_valid", {31'h0, ex_valid}, 32'h0);
    check("ar_ula_a", ula_a, 32'h0);
    check("ar_stall_cnt", {16'h0, stall_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
